verinject_fault_scheduler: RTL and testbench
============================================

// Module: verinject_fault_scheduler
// PURPOSE
//  Upstream driver for the memory/register fault injectors. Host loads a list of
//  (cycle, bit-index) fault entries into an internal FIFO, then starts a run; the
//  block counts run cycles and drives verinject__injector_state with each entry's
//  bit index for exactly one clock at its scheduled cycle, else the idle value.
//  Output fans out to every verinject_* injector, each decoding its own index range.
// PARAMETERS
//  DEPTH        8   schedule FIFO entries (power of two)
//  DEPTH_LOG2   3   log2(DEPTH)
//  IDLE_STATE   32'hFFFF_FFFF  injector_state value when no fault is presented
// PORTS
//  clock                     in   1   single clock, rising edge
//  reset_n                   in   1   asynchronous active-low reset
//  load_valid                in   1   host offers an entry
//  load_ready                out  1   entry accepted when valid&&ready
//  load_cycle                in   32  run cycle at which to inject
//  load_bit                  in   32  global bit index to flip
//  start                     in   1   pulse: begin run (IDLE only)
//  abort                     in   1   pulse: flush FIFO, return to IDLE
//  verinject__injector_state out  32  fault index to injectors (registered)
//  cycle_count               out  32  current run cycle
//  busy / done               out  1   in RUN / in DONE
//  order_err                 out  1   sticky: out-of-order load seen
//  late_count                out  8   saturating count of late entries
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, FIFO empty, injector_state=IDLE_STATE,
//   cycle_count=0, busy=0, done=0, order_err=0, late_count=0, last_loaded=0.
//  States: IDLE -(start)-> RUN -(FIFO empty, last entry emitted)-> DONE -(start)-> RUN;
//   abort from any state -> IDLE next edge, FIFO flushed, injector_state=IDLE_STATE,
//   order_err/late_count cleared; abort has priority over start and load.
//  load_ready = (state==IDLE) && !full. Entry with load_cycle >= last_loaded cycle
//   is pushed; load_cycle < last_loaded is consumed (handshake completes) but
//   discarded and sets order_err. Full FIFO: load_ready=0, nothing lost.
//  start in IDLE/DONE: cycle_count=0 in first RUN cycle, +1 per cycle, saturates at
//   32'hFFFF_FFFF. start with empty FIFO: one RUN cycle then DONE. start ignored in RUN.
//  Emission: injector_state equals head.bit during exactly the cycle where
//   cycle_count==head.cycle (compare against next count so output stays a flop);
//   head popped same edge. At most one emission per cycle.
//  Same-cycle entries: first emitted on time; each further one is late -> emitted
//   in following consecutive cycles, late_count+1 each (saturate at 255).
//  DONE: busy=0, done=1, injector_state=IDLE_STATE, cycle_count holds.
//  reset_n mid-run: immediate IDLE_STATE on output, schedule lost.
// CONFIGURATION
//  VERINJECT_SCHED_LATE_DROP_EN defined: late entries popped without emission
//   (injector_state stays IDLE_STATE), still counted in late_count.
//  Undefined: late entries emitted back-to-back as above.
// TESTING
//  1 load (3,17),(5,40); start -> state=17 only at cycle_count 3, 40 only at 5,
//    IDLE_STATE elsewhere; done=1 one cycle after count 5.
//  2 load (4,1),(4,2),(4,3) -> default: 1@4,2@5,3@6, late_count=2;
//    LATE_DROP_EN: 1@4 only, late_count=2.
//  3 load (10,7) then (6,9) -> second handshake completes, order_err=1, only 7
//    emitted at 10.
//  4 load DEPTH=8 entries -> load_ready=0 with 9th valid held; accepted after abort.
//  5 abort at cycle_count 2 of run with (5,33) -> IDLE next edge, 33 never emitted,
//    load_ready=1, order_err=0.
//  6 reset_n low mid-run (async, off-edge) -> injector_state=32'hFFFF_FFFF, busy=0
//    immediately; start afterwards with empty FIFO -> done after 1 cycle.

Source files
------------

// File: rtl/verinject_fault_scheduler.sv
// verinject_fault_scheduler: replays a host-loaded (cycle, bit) fault list onto verinject__injector_state during a run
// Ports: clock/reset_n (async active-low); load_valid/load_ready/load_cycle/load_bit host load channel;
//   start/abort run control; verinject__injector_state registered fault index (IDLE_STATE when idle);
//   cycle_count run cycle; busy/done run status; order_err sticky out-of-order load; late_count saturating late entries.
// Option: define VERINJECT_SCHED_LATE_DROP_EN to drop late entries instead of emitting them back-to-back.
module verinject_fault_scheduler #(
  parameter int          DEPTH      = 8,
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [31:0] IDLE_STATE = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_cycle,
  input  logic [31:0] load_bit,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] verinject__injector_state,
  output logic [31:0] cycle_count,
  output logic        busy,
  output logic        done,
  output logic        order_err,
  output logic [7:0]  late_count
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t              r_state, w_state_nxt;
  logic [31:0]         r_mem_cycle [DEPTH];
  logic [31:0]         r_mem_bit   [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]         r_last_loaded;
  logic [31:0]         w_head_cycle, w_head_bit, w_next_count;
  logic                w_empty, w_full, w_fire, w_push, w_run_nxt, w_pop, w_late, w_emit;
  assign w_empty      = r_wr_ptr == r_rd_ptr;
  assign w_full       = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                        (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_head_cycle = r_mem_cycle[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign w_head_bit   = r_mem_bit[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign load_ready   = (r_state == S_IDLE) && !w_full;
  assign busy         = r_state == S_RUN;
  assign done         = r_state == S_DONE;
  assign w_fire       = load_valid && load_ready && !abort;
  assign w_push       = w_fire && (load_cycle >= r_last_loaded);
  assign w_run_nxt    = w_state_nxt == S_RUN;
  // Emission is decided against the count the next cycle will show, so the output stays a flop.
  assign w_next_count = (r_state != S_RUN) ? 32'd0 : (&cycle_count) ? cycle_count : cycle_count + 32'd1;
  assign w_pop        = w_run_nxt && !w_empty && (w_head_cycle <= w_next_count);
  // A head whose cycle already passed lost its slot to an earlier same-cycle entry.
  assign w_late       = w_pop && (w_head_cycle < w_next_count);
`ifdef VERINJECT_SCHED_LATE_DROP_EN
  assign w_emit       = w_pop && !w_late;
`else
  assign w_emit       = w_pop;
`endif
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_empty ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = start ? S_RUN : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  always_ff @(posedge clock)
    if (w_push) begin
      r_mem_cycle[r_wr_ptr[DEPTH_LOG2-1:0]] <= load_cycle;
      r_mem_bit[r_wr_ptr[DEPTH_LOG2-1:0]]   <= load_bit;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_wr_ptr                 <= '0;
      r_rd_ptr                 <= '0;
      r_last_loaded            <= '0;
      verinject__injector_state <= IDLE_STATE;
      cycle_count              <= '0;
      order_err                <= 1'b0;
      late_count               <= '0;
    end else if (abort) begin
      r_wr_ptr                 <= '0;
      r_rd_ptr                 <= '0;
      r_last_loaded            <= '0;
      verinject__injector_state <= IDLE_STATE;
      cycle_count              <= '0;
      order_err                <= 1'b0;
      late_count               <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_push) r_last_loaded <= load_cycle;
      if (w_fire && !w_push) order_err <= 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_late && !(&late_count)) late_count <= late_count + 8'd1;
      verinject__injector_state <= w_emit ? w_head_bit : IDLE_STATE;
      if (w_run_nxt) cycle_count <= w_next_count;
    end
endmodule

// File: tb/tb_verinject_fault_scheduler.sv
// tb_verinject_fault_scheduler: scoreboard bench for the fault scheduler
module tb_verinject_fault_scheduler;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
  logic        clock = 1'b0, reset_n = 1'b0, load_valid = 1'b0, start = 1'b0, abort = 1'b0;
  logic [31:0] load_cycle = '0, load_bit = '0;
  logic        load_ready, busy, done, order_err;
  logic [31:0] inj, cycle_count;
  logic [7:0]  late_count;
  logic [63:0] q[$];
  int          n_cmp = 0, n_err = 0;
  verinject_fault_scheduler dut (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_cycle(load_cycle), .load_bit(load_bit), .start(start), .abort(abort),
    .verinject__injector_state(inj), .cycle_count(cycle_count), .busy(busy), .done(done),
    .order_err(order_err), .late_count(late_count)
  );
  always #5 clock = ~clock;
  task automatic load(input logic [31:0] c, input logic [31:0] b);
    @(negedge clock);
    load_cycle = c;
    load_bit   = b;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
  endtask
  task automatic do_abort();
    @(negedge clock) abort = 1'b1;
    @(negedge clock) abort = 1'b0;
  endtask
  task automatic run_check(input string nm, input logic [31:0] final_count);
    int t;
    logic [63:0] e;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    t = 0;
    while (!done && t < 200) begin
      if (inj !== IDLE) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL %s emission: got bit %0d at count %0d, required none", nm, inj, cycle_count);
        end else begin
          e = q.pop_front();
          if ({cycle_count, inj} !== e) begin
            n_err++;
            $display("FAIL %s emission: got bit %0d at count %0d, required bit %0d at count %0d",
                     nm, inj, cycle_count, e[31:0], e[63:32]);
          end
        end
      end
      @(negedge clock);
      t++;
    end
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL %s done timeout: done=%b required 1", nm, done); end
    n_cmp++;
    if (cycle_count !== final_count) begin
      n_err++; $display("FAIL %s final count: got %0d required %0d", nm, cycle_count, final_count);
    end
    n_cmp++;
    if (q.size() != 0) begin n_err++; $display("FAIL %s missing emissions: %0d left required 0", nm, q.size()); end
    n_cmp++;
    if (inj !== IDLE || busy !== 1'b0) begin
      n_err++; $display("FAIL %s done outputs: state=%h busy=%b required %h/0", nm, inj, busy, IDLE);
    end
    q.delete();
  endtask
  task automatic test_reset();
    #12 reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({inj, cycle_count, busy, done, order_err, late_count, load_ready} !== {IDLE, 32'd0, 3'b000, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: state=%h count=%0d busy=%b done=%b oe=%b late=%0d ready=%b, required %h 0 0 0 0 0 1",
               inj, cycle_count, busy, done, order_err, late_count, load_ready, IDLE);
    end
  endtask
  task automatic test_basic();
    load(3, 17);
    load(5, 40);
    q.push_back({32'd3, 32'd17});
    q.push_back({32'd5, 32'd40});
    run_check("basic", 5);
  endtask
  task automatic test_back_to_back();
    do_abort();
    load(4, 1);
    load(4, 2);
    load(4, 3);
    q.push_back({32'd4, 32'd1});
`ifndef VERINJECT_SCHED_LATE_DROP_EN
    q.push_back({32'd5, 32'd2});
    q.push_back({32'd6, 32'd3});
`endif
    run_check("back_to_back", 6);
    n_cmp++;
    if (late_count !== 8'd2) begin n_err++; $display("FAIL late_count: got %0d required 2", late_count); end
  endtask
  task automatic test_order();
    do_abort();
    load(10, 7);
    load(6, 9);
    n_cmp++;
    if (order_err !== 1'b1) begin n_err++; $display("FAIL order_err: got %b required 1", order_err); end
    q.push_back({32'd10, 32'd7});
    run_check("order", 10);
  endtask
  task automatic test_full();
    do_abort();
    for (int i = 0; i < 8; i++) load(20 + i, 100 + i);
    @(negedge clock);
    load_cycle = 9;
    load_bit   = 99;
    load_valid = 1'b1;
    n_cmp++;
    if (load_ready !== 1'b0) begin n_err++; $display("FAIL full ready: got %b required 0", load_ready); end
    @(negedge clock);
    n_cmp++;
    if (load_ready !== 1'b0) begin n_err++; $display("FAIL full ready held: got %b required 0", load_ready); end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b1) begin n_err++; $display("FAIL ready after abort: got %b required 1", load_ready); end
    @(negedge clock);
    load_valid = 1'b0;
    q.push_back({32'd9, 32'd99});
    run_check("full", 9);
  endtask
  task automatic test_abort();
    int t;
    logic seen;
    do_abort();
    load(5, 33);
    load(1, 2);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    t = 0;
    while (cycle_count != 2 && t < 50) begin @(negedge clock); t++; end
    n_cmp++;
    if (cycle_count !== 32'd2 || busy !== 1'b1) begin
      n_err++; $display("FAIL abort setup: count=%0d busy=%b required 2/1", cycle_count, busy);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, load_ready, order_err, late_count, inj} !== {4'b0010, 8'd0, IDLE}) begin
      n_err++;
      $display("FAIL abort: busy=%b done=%b ready=%b oe=%b late=%0d state=%h, required 0 0 1 0 0 %h",
               busy, done, load_ready, order_err, late_count, inj, IDLE);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); if (inj !== IDLE) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort emission: got %b required 0", seen); end
  endtask
  task automatic test_async_reset();
    int t;
    do_abort();
    load(3, 77);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    t = 0;
    while (inj !== 32'd77 && t < 50) begin @(negedge clock); t++; end
    n_cmp++;
    if (inj !== 32'd77 || cycle_count !== 32'd3) begin
      n_err++; $display("FAIL async setup: state=%0d count=%0d required 77/3", inj, cycle_count);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (inj !== IDLE || busy !== 1'b0 || cycle_count !== 32'd0) begin
      n_err++; $display("FAIL async reset: state=%h busy=%b count=%0d required %h/0/0", inj, busy, cycle_count, IDLE);
    end
    #5 reset_n = 1'b1;
    run_check("empty_start", 0);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_order();
    test_full();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
